// File: rtl/imr_adc_mc_serial_core_if.sv
// imr_adc_mc_serial_core_if: show-ahead sample FIFO read port between the ADC core and its register block.
interface imr_adc_mc_serial_core_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_BITS  = 12,
    parameter int FIFO_DEPTH = 16
);
    logic                          Fifo_Rd;
    logic [NUM_CH*DATA_BITS-1:0]   Fifo_Data;
    logic [$clog2(FIFO_DEPTH):0]   Fifo_Level;
    logic                          Fifo_Empty;

    modport master (output Fifo_Rd, input Fifo_Data, Fifo_Level, Fifo_Empty);
    modport slave  (input Fifo_Rd, output Fifo_Data, Fifo_Level, Fifo_Empty);
endinterface

// File: rtl/imr_adc_mc_serial_core.sv
// imr_adc_mc_serial_core: shared SCLK/CS_n multi-channel serial ADC sequencer with sample FIFO and level IRQ.
// Define IMR_ADC_MC_FRAME_CHECK_EN to flag nonzero frame padding bits per channel in Frame_Err.
module imr_adc_mc_serial_core #(
    parameter int NUM_CH     = 2,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int QUIET_CLKS = 8
) (
    input  logic                        SysClk,
    input  logic                        RST_n,
    input  logic                        Enable,
    input  logic                        Start,
    input  logic                        Stop,
    input  logic                        Continuous,
    input  logic [7:0]                  ClkDiv_N,
    input  logic [15:0]                 TotalConversions,
    input  logic [15:0]                 SamplePeriod,
    input  logic [NUM_CH-1:0]           MISO,
    output logic                        SCLK,
    output logic                        CS_n,
    imr_adc_mc_serial_core_if.slave     fifo,
    output logic                        Overrun,
    input  logic                        IRQ_Enable,
    input  logic                        IRQ_Clear,
    input  logic [$clog2(FIFO_DEPTH):0] IRQ_Thresh,
    output logic                        Busy,
    output logic [2:0]                  State,
    output logic [15:0]                 ConvCount,
    output logic                        IP_IRQ,
    output logic [NUM_CH-1:0]           Frame_Err
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef IMR_ADC_MC_FRAME_CHECK_EN
    localparam int SRW = FRAME_BITS;
`else
    localparam int SRW = DATA_BITS;
`endif

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_SHIFT, S_LATCH, S_QUIET} state_t;
    state_t st, nxt;

    logic start_q, stop_q, stop_pend, rise_q, irq_pend;
    logic [15:0] cnt, timer;
    logic [5:0] bits;
    logic [NUM_CH-1:0][SRW-1:0] sr;
    logic [NUM_CH*DATA_BITS-1:0] word;
    logic [NUM_CH*DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] level;
    logic [7:0] div;
    logic start_rise, stop_rise, div_hit, done, latch, full, rd, push, seq_start, irq_set;

    assign start_rise = Start & ~start_q;
    assign stop_rise  = Stop & ~stop_q;
    assign div        = ClkDiv_N < 8'd2 ? 8'd2 : ClkDiv_N;
    assign div_hit    = cnt == {8'd0, div - 8'd1};
    assign done       = ~Continuous | (TotalConversions != '0 && ConvCount == TotalConversions) | stop_pend | stop_rise;
    assign seq_start  = st == S_IDLE && nxt == S_START;
    assign latch      = st == S_LATCH && Enable;
    assign full       = level == (AW+1)'(FIFO_DEPTH);
    assign rd         = fifo.Fifo_Rd && level != '0;
    assign push       = latch && (!full || rd);
    assign irq_set    = (IRQ_Thresh != '0 && level >= IRQ_Thresh) || (st == S_QUIET && nxt == S_IDLE);

    assign fifo.Fifo_Level = level;
    assign fifo.Fifo_Empty = level == '0;
    assign fifo.Fifo_Data  = level == '0 ? '0 : mem[rp];
    assign Busy   = st != S_IDLE;
    assign State  = st;
    assign IP_IRQ = IRQ_Enable & irq_pend;

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_CH; k++) word[k*DATA_BITS +: DATA_BITS] = sr[k][DATA_BITS-1:0];
    end

    always_ff @(posedge SysClk or negedge RST_n)
        if (!RST_n) st <= S_IDLE;
        else st <= nxt;

    always_comb begin
        nxt = st;
        case (st)
            S_IDLE:  if (start_rise) nxt = S_START;
            S_WAIT:  nxt = stop_rise ? S_IDLE : timer <= 16'd1 ? S_START : S_WAIT;
            S_START: nxt = stop_rise ? S_IDLE : S_SHIFT;
            // leave SHIFT on the falling toggle after the last sample so every bit gets a full SCLK period
            S_SHIFT: if (div_hit && SCLK && bits == 6'(FRAME_BITS)) nxt = S_LATCH;
            S_LATCH: nxt = S_QUIET;
            S_QUIET: if (cnt == 16'(QUIET_CLKS - 1))
                         nxt = done ? S_IDLE : (SamplePeriod != '0 && timer > 16'd1) ? S_WAIT : S_START;
            default: nxt = S_IDLE;
        endcase
        if (!Enable) nxt = S_IDLE;
    end

    always_ff @(posedge SysClk or negedge RST_n) begin
        if (!RST_n) begin
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            stop_pend <= 1'b0;
            rise_q    <= 1'b0;
            cnt       <= '0;
            timer     <= '0;
            bits      <= '0;
            sr        <= '0;
            SCLK      <= 1'b0;
            CS_n      <= 1'b1;
            ConvCount <= '0;
            Overrun   <= 1'b0;
        end else begin
            start_q <= Start;
            stop_q  <= Stop;
            SCLK    <= st == S_SHIFT && nxt == S_SHIFT ? SCLK ^ div_hit : 1'b0;
            rise_q  <= st == S_SHIFT && nxt == S_SHIFT && div_hit && !SCLK;
            cnt     <= st != nxt || (st == S_SHIFT && div_hit) ? '0 : cnt + 16'd1;
            CS_n    <= !(nxt inside {S_START, S_SHIFT, S_LATCH});
            // timer holds cycles left until the next START, so the CS_n falling edges land SamplePeriod apart
            timer   <= st == S_START ? (SamplePeriod == '0 ? '0 : SamplePeriod - 16'd1)
                                     : (timer == '0 ? '0 : timer - 16'd1);
            if (st == S_START) bits <= '0;
            else if (st == S_SHIFT && rise_q) begin
                bits <= bits + 6'd1;
                for (int k = 0; k < NUM_CH; k++) sr[k] <= {sr[k][SRW-2:0], MISO[k]};
            end
            if (latch) begin
                ConvCount <= ConvCount + 16'd1;
                if (full && !rd) Overrun <= 1'b1;
            end
            if (stop_rise && st != S_IDLE) stop_pend <= 1'b1;
            if (seq_start) begin
                ConvCount <= '0;
                Overrun   <= 1'b0;
                stop_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge SysClk or negedge RST_n) begin
        if (!RST_n) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            irq_pend <= 1'b0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (rd) rp <= rp + AW'(1);
            level    <= level + (AW+1)'(push) - (AW+1)'(rd);
            irq_pend <= IRQ_Clear ? 1'b0 : irq_set ? 1'b1 : irq_pend;
        end
    end

    always_ff @(posedge SysClk)
        if (push) mem[wp] <= word;

`ifdef IMR_ADC_MC_FRAME_CHECK_EN
    logic [NUM_CH-1:0] pad_err;
    always_comb begin
        pad_err = '0;
        for (int k = 0; k < NUM_CH; k++) pad_err[k] = (sr[k] >> DATA_BITS) != '0;
    end
    always_ff @(posedge SysClk or negedge RST_n)
        if (!RST_n) Frame_Err <= '0;
        else if (seq_start) Frame_Err <= '0;
        else if (latch) Frame_Err <= Frame_Err | pad_err;
`else
    assign Frame_Err = '0;
`endif
endmodule
